// File: rtl/alu_pipe_regs.sv
// alu_pipe_regs: execute/memory slice of the 10-bit three-stage CPU.
// FD->EM operand register, combinational ALU and data-memory drive in EM,
// EM->WB register and the final write-back select.
// Build option: define WB_FORWARD_EN to bypass the write-back value into the
// EM operands when the instruction in WB targets one of the EM source registers.
module alu_pipe_regs #(
    parameter int DATA_W = 10,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] fd_src_addr,
    input  logic [REG_AW-1:0] fd_dest_addr,
    input  logic [DATA_W-1:0] fd_alu_a,
    input  logic [DATA_W-1:0] fd_alu_b,
    input  logic [2:0]        fd_alu_ctrl,
    input  logic              fd_reg_we,
    input  logic              fd_mem_we,
    input  logic              fd_mem_re,
    input  logic [DATA_W-1:0] fd_store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_halt,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_wdata
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_SLR  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    logic [REG_AW-1:0] em_src_addr_q;
    logic [REG_AW-1:0] em_dest_addr_q;
    logic [DATA_W-1:0] em_a_q;
    logic [DATA_W-1:0] em_b_q;
    logic [2:0]        em_ctrl_q;
    logic              em_reg_we_q;
    logic              em_mem_we_q;
    logic              em_mem_re_q;
    logic [DATA_W-1:0] em_store_q;

    logic [DATA_W-1:0] wb_alu_q;
    logic [DATA_W-1:0] wb_rdata_q;
    logic              wb_we_q;
    logic              wb_mem_re_q;
    logic [REG_AW-1:0] wb_dest_q;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] store_eff;
    logic [3:0]        alu_sh;
    logic [DATA_W-1:0] alu_res_d;
    logic              alu_halt_d;

    // FD->EM register; reset turns the stage into a bubble (ADD 0,0, no writes)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            em_src_addr_q  <= '0;
            em_dest_addr_q <= '0;
            em_a_q         <= '0;
            em_b_q         <= '0;
            em_ctrl_q      <= '0;
            em_reg_we_q    <= 1'b0;
            em_mem_we_q    <= 1'b0;
            em_mem_re_q    <= 1'b0;
            em_store_q     <= '0;
        end else begin
            em_src_addr_q  <= fd_src_addr;
            em_dest_addr_q <= fd_dest_addr;
            em_a_q         <= fd_alu_a;
            em_b_q         <= fd_alu_b;
            em_ctrl_q      <= fd_alu_ctrl;
            em_reg_we_q    <= fd_reg_we;
            em_mem_we_q    <= fd_mem_we;
            em_mem_re_q    <= fd_mem_re;
            em_store_q     <= fd_store_data;
        end
    end

`ifdef WB_FORWARD_EN
    logic fwd_a;
    logic fwd_b;

    // Bypass the value being written back this cycle into the EM operands
    always_comb begin
        fwd_a     = wb_we_q && (wb_dest_q == em_src_addr_q);
        fwd_b     = wb_we_q && (wb_dest_q == em_dest_addr_q);
        op_a      = fwd_a ? wb_wdata : em_a_q;
        op_b      = fwd_b ? wb_wdata : em_b_q;
        store_eff = fwd_b ? wb_wdata : em_store_q;
    end
`else
    // Source address is only needed by the bypass comparators
    logic unused_src_addr;
    assign unused_src_addr = ^em_src_addr_q;

    // Operands straight from the FD->EM register
    always_comb begin
        op_a      = em_a_q;
        op_b      = em_b_q;
        store_eff = em_store_q;
    end
`endif

    // ALU; shifts use only B[3:0] and saturate to zero past the datapath width
    always_comb begin
        alu_res_d  = '0;
        alu_halt_d = 1'b0;
        alu_sh     = op_b[3:0];
        case (em_ctrl_q)
            OP_ADD:  alu_res_d = op_a + op_b;
            OP_SUB:  alu_res_d = op_a - op_b;
            OP_SLT:  alu_res_d = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NAND: alu_res_d = ~(op_a & op_b);
            OP_SLR:  alu_res_d = (int'(alu_sh) >= DATA_W) ? '0 : (op_a >> alu_sh);
            OP_SLL:  alu_res_d = (int'(alu_sh) >= DATA_W) ? '0 : (op_a << alu_sh);
            OP_HALT: alu_halt_d = 1'b1;
            default: alu_res_d = '0;
        endcase
    end

    assign alu_result = alu_res_d;
    assign alu_halt   = alu_halt_d;
    assign mem_addr   = alu_res_d;
    assign mem_we     = em_mem_we_q;
    assign mem_wdata  = em_mem_we_q ? store_eff : '0;

    // EM->WB register; reset clears write enable so nothing reaches the register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_alu_q    <= '0;
            wb_rdata_q  <= '0;
            wb_we_q     <= 1'b0;
            wb_mem_re_q <= 1'b0;
            wb_dest_q   <= '0;
        end else begin
            wb_alu_q    <= alu_res_d;
            wb_rdata_q  <= mem_rdata;
            wb_we_q     <= em_reg_we_q;
            wb_mem_re_q <= em_mem_re_q;
            wb_dest_q   <= em_dest_addr_q;
        end
    end

    assign wb_we    = wb_we_q;
    assign wb_dest  = wb_dest_q;
    assign wb_wdata = wb_mem_re_q ? wb_rdata_q : wb_alu_q;

endmodule

// File: tb/tb_alu_pipe_regs.sv
// Self-checking bench for alu_pipe_regs: expected EM and WB results are queued
// when an instruction is driven and compared when it reaches that stage.
module tb_alu_pipe_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] fd_src_addr, fd_dest_addr, fd_alu_ctrl;
    logic [9:0] fd_alu_a, fd_alu_b, fd_store_data, mem_rdata;
    logic       fd_reg_we, fd_mem_we, fd_mem_re;
    logic [9:0] mem_addr, mem_wdata, alu_result, wb_wdata;
    logic       mem_we, alu_halt, wb_we;
    logic [2:0] wb_dest;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [9:0] alu;
        logic       halt;
    } em_exp_t;

    typedef struct packed {
        logic       we;
        logic [2:0] dest;
        logic [9:0] data;
    } wb_exp_t;

    em_exp_t em_q[$];
    wb_exp_t wb_q[$];

    localparam logic [9:0] SW_A [0:9] = '{10'h005, 10'h005, 10'h005, 10'h005, 10'h3FF,
                                          10'h001, 10'h001, 10'h3FF, 10'h005, 10'h200};
    localparam logic [9:0] SW_B [0:9] = '{10'h003, 10'h003, 10'h003, 10'h003, 10'h001,
                                          10'h3FF, 10'h3FF, 10'h3FF, 10'h003, 10'h000};
    localparam logic [2:0] SW_OP[0:9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 3'd0, 3'd7, 3'd3};
    localparam logic [9:0] SW_R [0:9] = '{10'h008, 10'h002, 10'h000, 10'h3FE, 10'h001,
                                          10'h002, 10'h000, 10'h3FE, 10'h000, 10'h3FF};

    localparam logic [9:0] SH_A [0:8] = '{10'h081, 10'h081, 10'h081, 10'h081, 10'h200,
                                          10'h001, 10'h3FF, 10'h005, 10'h081};
    localparam logic [9:0] SH_B [0:8] = '{10'h002, 10'h002, 10'h00C, 10'h00C, 10'h009,
                                          10'h009, 10'h00A, 10'h003, 10'h012};
    localparam logic [2:0] SH_OP[0:8] = '{3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5, 3'd4, 3'd6, 3'd4};
    localparam logic [9:0] SH_R [0:8] = '{10'h020, 10'h204, 10'h000, 10'h000, 10'h001,
                                          10'h200, 10'h000, 10'h000, 10'h020};
    localparam logic       SH_H [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    alu_pipe_regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fd_src_addr  (fd_src_addr),
        .fd_dest_addr (fd_dest_addr),
        .fd_alu_a     (fd_alu_a),
        .fd_alu_b     (fd_alu_b),
        .fd_alu_ctrl  (fd_alu_ctrl),
        .fd_reg_we    (fd_reg_we),
        .fd_mem_we    (fd_mem_we),
        .fd_mem_re    (fd_mem_re),
        .fd_store_data(fd_store_data),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .alu_result   (alu_result),
        .alu_halt     (alu_halt),
        .wb_we        (wb_we),
        .wb_dest      (wb_dest),
        .wb_wdata     (wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] src, input logic [2:0] dest,
                         input logic [9:0] a, input logic [9:0] b, input logic [2:0] op,
                         input logic rwe, input logic mwe, input logic mre,
                         input logic [9:0] sd);
        fd_src_addr   = src;
        fd_dest_addr  = dest;
        fd_alu_a      = a;
        fd_alu_b      = b;
        fd_alu_ctrl   = op;
        fd_reg_we     = rwe;
        fd_mem_we     = mwe;
        fd_mem_re     = mre;
        fd_store_data = sd;
    endtask

    task automatic bubble();
        drive(3'd0, 3'd0, 10'h0, 10'h0, 3'd0, 1'b0, 1'b0, 1'b0, 10'h0);
    endtask

    task automatic test_reset();
        mem_rdata = 10'h123;
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'd1, 3'd1, 10'h3FF, 10'h3FF, 3'd6, 1'b1, 1'b1, 1'b1, 10'h3FF);
        repeat (2) @(negedge clk);
        checks++; if (alu_result !== 10'h0) begin failures++; $display("FAIL rst_alu_result got=%h exp=000", alu_result); end
        checks++; if (alu_halt !== 1'b0) begin failures++; $display("FAIL rst_alu_halt got=%b exp=0", alu_halt); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_wdata !== 10'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=000", mem_wdata); end
        checks++; if (mem_addr !== 10'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=000", mem_addr); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL rst_wb_we got=%b exp=0", wb_we); end
        checks++; if (wb_dest !== 3'd0) begin failures++; $display("FAIL rst_wb_dest got=%0d exp=0", wb_dest); end
        checks++; if (wb_wdata !== 10'h0) begin failures++; $display("FAIL rst_wb_wdata got=%h exp=000", wb_wdata); end
        rst_n = 1'b1;
        drive(3'd6, 3'd3, 10'h001, 10'h002, 3'd0, 1'b1, 1'b0, 1'b0, 10'h0);
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL rel_wb_we_early got=%b exp=0", wb_we); end
        checks++; if (alu_result !== 10'h003) begin failures++; $display("FAIL rel_alu_result got=%h exp=003", alu_result); end
        bubble();
        @(negedge clk);
        checks++; if (wb_we !== 1'b1) begin failures++; $display("FAIL rel_wb_we got=%b exp=1", wb_we); end
        checks++; if (wb_dest !== 3'd3) begin failures++; $display("FAIL rel_wb_dest got=%0d exp=3", wb_dest); end
        checks++; if (wb_wdata !== 10'h003) begin failures++; $display("FAIL rel_wb_wdata got=%h exp=003", wb_wdata); end
    endtask

    task automatic test_alu_sweep();
        em_exp_t ev;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (em_q.size() == 0) begin
                    failures++; $display("FAIL sweep_queue[%0d] got=empty exp=entry", i - 1);
                end else begin
                    ev = em_q.pop_front();
                    if (alu_result !== ev.alu) begin failures++; $display("FAIL sweep_alu[%0d] got=%h exp=%h", i - 1, alu_result, ev.alu); end
                    checks++; if (alu_halt !== ev.halt) begin failures++; $display("FAIL sweep_halt[%0d] got=%b exp=%b", i - 1, alu_halt, ev.halt); end
                    checks++; if (mem_addr !== ev.alu) begin failures++; $display("FAIL sweep_mem_addr[%0d] got=%h exp=%h", i - 1, mem_addr, ev.alu); end
                end
            end
            if (i < 10) begin
                drive(3'd6, 3'd7, SW_A[i], SW_B[i], SW_OP[i], 1'b0, 1'b0, 1'b0, 10'h0);
                ev.alu = SW_R[i]; ev.halt = 1'b0;
                em_q.push_back(ev);
            end else begin
                bubble();
            end
        end
    endtask

    task automatic test_shift_halt();
        em_exp_t ev;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (em_q.size() == 0) begin
                    failures++; $display("FAIL shift_queue[%0d] got=empty exp=entry", i - 1);
                end else begin
                    ev = em_q.pop_front();
                    if (alu_result !== ev.alu) begin failures++; $display("FAIL shift_alu[%0d] got=%h exp=%h", i - 1, alu_result, ev.alu); end
                    checks++; if (alu_halt !== ev.halt) begin failures++; $display("FAIL shift_halt[%0d] got=%b exp=%b", i - 1, alu_halt, ev.halt); end
                end
            end
            if (i < 9) begin
                drive(3'd6, 3'd7, SH_A[i], SH_B[i], SH_OP[i], 1'b0, 1'b0, 1'b0, 10'h0);
                ev.alu = SH_R[i]; ev.halt = SH_H[i];
                em_q.push_back(ev);
            end else begin
                bubble();
            end
        end
    endtask

    task automatic test_load_store();
        wb_exp_t wv;
        @(negedge clk);
        drive(3'd6, 3'd7, 10'h004, 10'h001, 3'd0, 1'b0, 1'b1, 1'b0, 10'h155);
        @(negedge clk);
        checks++; if (mem_addr !== 10'h005) begin failures++; $display("FAIL st_mem_addr got=%h exp=005", mem_addr); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL st_mem_we got=%b exp=1", mem_we); end
        checks++; if (mem_wdata !== 10'h155) begin failures++; $display("FAIL st_mem_wdata got=%h exp=155", mem_wdata); end
        mem_rdata = 10'h2AA;
        drive(3'd6, 3'd4, 10'h004, 10'h001, 3'd0, 1'b1, 1'b0, 1'b0, 10'h155);
        wv.we = 1'b1; wv.dest = 3'd4; wv.data = 10'h005;
        wb_q.push_back(wv);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ns_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_wdata !== 10'h0) begin failures++; $display("FAIL ns_mem_wdata got=%h exp=000", mem_wdata); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL st_wb_we got=%b exp=0", wb_we); end
        drive(3'd6, 3'd5, 10'h002, 10'h000, 3'd0, 1'b1, 1'b0, 1'b1, 10'h0);
        wv.we = 1'b1; wv.dest = 3'd5; wv.data = 10'h2AA;
        wb_q.push_back(wv);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bubble();
            checks++;
            if (wb_q.size() == 0) begin
                failures++; $display("FAIL ld_queue[%0d] got=empty exp=entry", k);
            end else begin
                wv = wb_q.pop_front();
                if (wb_we !== wv.we) begin failures++; $display("FAIL ld_wb_we[%0d] got=%b exp=%b", k, wb_we, wv.we); end
                checks++; if (wb_dest !== wv.dest) begin failures++; $display("FAIL ld_wb_dest[%0d] got=%0d exp=%0d", k, wb_dest, wv.dest); end
                checks++; if (wb_wdata !== wv.data) begin failures++; $display("FAIL ld_wb_wdata[%0d] got=%h exp=%h", k, wb_wdata, wv.data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_a_fwd, exp_b_fwd, exp_sd_fwd;
`ifdef WB_FORWARD_EN
        exp_a_fwd  = 10'h007;
        exp_b_fwd  = 10'h016;
        exp_sd_fwd = 10'h015;
`else
        exp_a_fwd  = 10'h000;
        exp_b_fwd  = 10'h001;
        exp_sd_fwd = 10'h000;
`endif
        @(negedge clk);
        drive(3'd6, 3'd1, 10'h003, 10'h004, 3'd0, 1'b1, 1'b0, 1'b0, 10'h0);
        @(negedge clk);
        checks++; if (alu_result !== 10'h007) begin failures++; $display("FAIL b2b_first got=%h exp=007", alu_result); end
        drive(3'd1, 3'd2, 10'h000, 10'h000, 3'd0, 1'b0, 1'b0, 1'b0, 10'h0);
        @(negedge clk);
        checks++; if (alu_result !== exp_a_fwd) begin failures++; $display("FAIL b2b_fwd_a got=%h exp=%h", alu_result, exp_a_fwd); end
        checks++; if (wb_wdata !== 10'h007 || wb_dest !== 3'd1 || wb_we !== 1'b1) begin
            failures++; $display("FAIL b2b_wb got=%b/%0d/%h exp=1/1/007", wb_we, wb_dest, wb_wdata);
        end
        drive(3'd6, 3'd2, 10'h010, 10'h005, 3'd0, 1'b1, 1'b0, 1'b0, 10'h0);
        @(negedge clk);
        checks++; if (alu_result !== 10'h015) begin failures++; $display("FAIL b2b_third got=%h exp=015", alu_result); end
        drive(3'd6, 3'd2, 10'h001, 10'h000, 3'd0, 1'b0, 1'b1, 1'b0, 10'h000);
        @(negedge clk);
        checks++; if (alu_result !== exp_b_fwd) begin failures++; $display("FAIL b2b_fwd_b got=%h exp=%h", alu_result, exp_b_fwd); end
        checks++; if (mem_wdata !== exp_sd_fwd) begin failures++; $display("FAIL b2b_fwd_store got=%h exp=%h", mem_wdata, exp_sd_fwd); end
        bubble();
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        drive(3'd6, 3'd3, 10'h001, 10'h001, 3'd0, 1'b1, 1'b1, 1'b0, 10'h0AA);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_pre_mem_we got=%b exp=1", mem_we); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL mid_wb_we got=%b exp=0", wb_we); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_mem_we got=%b exp=0", mem_we); end
        checks++; if (alu_result !== 10'h0) begin failures++; $display("FAIL mid_alu got=%h exp=000", alu_result); end
        rst_n = 1'b1;
        bubble();
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL mid_wb_we_after got=%b exp=0", wb_we); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        mem_rdata = 10'h0;
        bubble();
        test_reset();
        test_alu_sweep();
        test_shift_halt();
        test_load_store();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
